// File: rtl/qeciphy_pkg.sv
// qeciphy_pkg: shared types and helpers for the QEC PHY clocking logic.
//   clk_ctrl_state_t : state encoding of the MMCM bring-up controller
//                      (exported on its debug `state` port).
//   cnt_width()      : bit width needed for a counter that must hold 0..v.
//   max_u()          : larger of two unsigned values.
package qeciphy_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RESET    = 3'd1,
        WAIT_CLK = 3'd2,
        SETTLE   = 3'd3,
        READY    = 3'd4,
        FAULT    = 3'd5
    } clk_ctrl_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Never returns 0 so that a counter declared from it is always a legal vector.
    function automatic int unsigned cnt_width(input int unsigned v);
        return (v == 0) ? 1 : $clog2(v + 1);
    endfunction

endpackage

// File: rtl/qeciphy_bit_sync.sv
// qeciphy_bit_sync: two-flop synchroniser for a single level signal.
//   clk : destination clock
//   rst : synchronous active-high reset, clears both stages
//   d   : asynchronous input
//   q   : synchronised output (2 clk cycles of latency)
module qeciphy_bit_sync (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/qeciphy_clk_mmcm_ctrl.sv
// qeciphy_clk_mmcm_ctrl: bring-up and recovery sequencer for the MMCM.
// Runs on a free-running clock, pulses the MMCM reset, waits for the input
// clock to be present, lets the outputs settle, and re-issues reset when the
// input clock is lost.
//   clk               : free-running controller clock
//   rst               : synchronous active-high reset
//   enable            : request clocking; low forces IDLE and clears counts
//   input_clk_stopped : MMCM input-clock-lost flag (asynchronous)
//   mmcm_reset        : MMCM reset (registered)
//   clk_ready         : MMCM output clocks usable (registered)
//   fault             : retry budget exhausted (registered)
//   retry_count       : failed attempts since rst / enable low, saturating
//   state             : current FSM state, for debug
module qeciphy_clk_mmcm_ctrl
    import qeciphy_pkg::*;
#(
    parameter int unsigned RESET_PULSE_CYCLES = 16,
    parameter int unsigned SETTLE_CYCLES      = 4096,
    parameter int unsigned STOP_FILTER_CYCLES = 8,
    parameter int unsigned MAX_RETRIES        = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       input_clk_stopped,
    output logic       mmcm_reset,
    output logic       clk_ready,
    output logic       fault,
    output logic [7:0] retry_count,
    output logic [2:0] state
);

    localparam int unsigned TIMER_W = cnt_width(max_u(RESET_PULSE_CYCLES, SETTLE_CYCLES));
    localparam int unsigned FILT_W  = cnt_width(STOP_FILTER_CYCLES);
    localparam int unsigned FAIL_W  = cnt_width(MAX_RETRIES);

    localparam logic [TIMER_W-1:0] RESET_LAST  = TIMER_W'(RESET_PULSE_CYCLES - 1);
    localparam logic [TIMER_W-1:0] SETTLE_LAST = TIMER_W'(SETTLE_CYCLES - 1);
    localparam logic [FILT_W-1:0]  FILT_MAX    = FILT_W'(STOP_FILTER_CYCLES);
    localparam logic [FAIL_W-1:0]  FAIL_MAX    = FAIL_W'(MAX_RETRIES);

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic              stop_s;
    logic              stop_f;
    logic [FILT_W-1:0] filt_q;

    qeciphy_bit_sync u_stop_sync (
        .clk (clk),
        .rst (rst),
        .d   (input_clk_stopped),
        .q   (stop_s)
    );

    always_ff @(posedge clk) begin
        if (rst || !stop_s) begin
            filt_q <= '0;
        end else if (filt_q != FILT_MAX) begin
            filt_q <= filt_q + 1'b1;
        end
    end

    // Gated with stop_s so a stale saturated count cannot flag a loss on the
    // cycle the flag has already cleared.
    assign stop_f = stop_s && (filt_q == FILT_MAX);

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    clk_ctrl_state_t     state_q, state_d;
    logic [TIMER_W-1:0]  timer_q, timer_d;
    logic [FAIL_W-1:0]   fail_q, fail_d;
    logic [7:0]          retry_q, retry_d;
    logic                fail_event;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        fail_d     = fail_q;
        retry_d    = retry_q;
        fail_event = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            timer_d = '0;
            fail_d  = '0;
            retry_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = RESET;
                    timer_d = '0;
                end
                RESET: begin
                    if (timer_q == RESET_LAST) begin
                        state_d = WAIT_CLK;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                WAIT_CLK: begin
                    if (!stop_s) begin
                        state_d = SETTLE;
                        timer_d = '0;
                    end else if (timer_q == SETTLE_LAST) begin
                        fail_event = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                SETTLE: begin
                    // Loss outranks completion; a short blip only restarts.
                    if (stop_f) begin
                        fail_event = 1'b1;
                    end else if (stop_s) begin
                        timer_d = '0;
                    end else if (timer_q == SETTLE_LAST) begin
                        state_d = READY;
                        timer_d = '0;
                        fail_d  = '0;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                READY: begin
                    if (stop_f) begin
                        fail_event = 1'b1;
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = IDLE;
                    timer_d = '0;
                end
            endcase
        end

        if (fail_event) begin
            timer_d = '0;
            if (retry_q != 8'hFF) begin
                retry_d = retry_q + 8'd1;
            end
            if ((MAX_RETRIES != 0) && (fail_q == FAIL_MAX)) begin
                state_d = FAULT;
            end else begin
                state_d = RESET;
                if (MAX_RETRIES != 0) begin
                    fail_d = fail_q + 1'b1;
                end
            end
        end
    end

    // Outputs decode the next state so they move on the same edge as state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            fail_q     <= '0;
            retry_q    <= '0;
            mmcm_reset <= 1'b1;
            clk_ready  <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            fail_q     <= fail_d;
            retry_q    <= retry_d;
            mmcm_reset <= (state_d == IDLE) || (state_d == RESET) || (state_d == FAULT);
            clk_ready  <= (state_d == READY);
            fault      <= (state_d == FAULT);
        end
    end

    assign retry_count = retry_q;
    assign state       = state_q;

endmodule

// File: tb/tb_qeciphy_clk_mmcm_ctrl.sv
// tb_qeciphy_clk_mmcm_ctrl: directed bench for the MMCM bring-up controller.
// Stimulus pushes cycle-tagged expected output vectors into a scoreboard;
// a monitor compares on the falling edge of the matching cycle.
module tb_qeciphy_clk_mmcm_ctrl;
    import qeciphy_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       input_clk_stopped;
    logic       mmcm_reset;
    logic       clk_ready;
    logic       fault;
    logic [7:0] retry_count;
    logic [2:0] state;

    qeciphy_clk_mmcm_ctrl #(
        .RESET_PULSE_CYCLES (4),
        .SETTLE_CYCLES      (16),
        .STOP_FILTER_CYCLES (3),
        .MAX_RETRIES        (2)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .enable            (enable),
        .input_clk_stopped (input_clk_stopped),
        .mmcm_reset        (mmcm_reset),
        .clk_ready         (clk_ready),
        .fault             (fault),
        .retry_count       (retry_count),
        .state             (state)
    );

    always #5 clk = ~clk;

    // Cycle index: value N during the cycle that follows rising edge N.
    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned at;
        string       name;
        logic [13:0] vec;   // {state, mmcm_reset, clk_ready, fault, retry_count}
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic exp_at(input int unsigned at, input string name,
                          input clk_ctrl_state_t st, input bit mr, input bit cr,
                          input bit ft, input int unsigned rc);
        exp_t e;
        int   i;
        e.at   = at;
        e.name = name;
        e.vec  = {3'(st), mr, cr, ft, 8'(rc)};
        i = sb.size();
        while (i > 0 && sb[i-1].at > at) i--;
        sb.insert(i, e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor
    always @(negedge clk) begin
        logic [13:0] got;
        exp_t        e;
        got = {state, mmcm_reset, clk_ready, fault, retry_count};
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            e = sb.pop_front();
            n_checks++;
            if (e.at != cyc) begin
                n_errors++;
                $display("FAIL %s: expectation for cycle %0d was not compared (now cycle %0d)",
                         e.name, e.at, cyc);
            end else if (got !== e.vec) begin
                n_errors++;
                $display("FAIL %s @%0d: got st=%0d mr=%0b cr=%0b flt=%0b rc=%0d, expected st=%0d mr=%0b cr=%0b flt=%0b rc=%0d",
                         e.name, cyc, got[13:11], got[10], got[9], got[8], got[7:0],
                         e.vec[13:11], e.vec[10], e.vec[9], e.vec[8], e.vec[7:0]);
            end
        end
    end

    initial begin
        int unsigned c;
        rst               = 1'b1;
        enable            = 1'b0;
        input_clk_stopped = 1'b0;

        // Reset state
        @(negedge clk);
        c = cyc;
        exp_at(c + 1, "rst_state", IDLE, 1, 0, 0, 0);
        step(1);
        rst = 1'b0;

        // 1: clean bring-up: 4-cycle reset pulse, 1 WAIT_CLK + 16 SETTLE cycles
        c = cyc;
        enable = 1'b1;
        exp_at(c + 1,  "s1_reset_first", RESET,    1, 0, 0, 0);
        exp_at(c + 4,  "s1_reset_last",  RESET,    1, 0, 0, 0);
        exp_at(c + 5,  "s1_reset_fall",  WAIT_CLK, 0, 0, 0, 0);
        exp_at(c + 6,  "s1_settle",      SETTLE,   0, 0, 0, 0);
        exp_at(c + 21, "s1_settle_last", SETTLE,   0, 0, 0, 0);
        exp_at(c + 22, "s1_ready",       READY,    0, 1, 0, 0);
        step(25);

        // 2a: 2-cycle stop blip is filtered out
        c = cyc;
        input_clk_stopped = 1'b1;
        exp_at(c + 6,  "s2_blip_ready",  READY, 0, 1, 0, 0);
        exp_at(c + 12, "s2_blip_ready2", READY, 0, 1, 0, 0);
        step(2);
        input_clk_stopped = 1'b0;
        step(10);

        // 2b: sustained loss: first sampled at c+1, acted on 5 edges later
        c = cyc;
        input_clk_stopped = 1'b1;
        exp_at(c + 5,  "s2_loss_pending", READY,    0, 1, 0, 0);
        exp_at(c + 6,  "s2_loss_reset",   RESET,    1, 0, 0, 1);
        exp_at(c + 9,  "s2_loss_rst_end", RESET,    1, 0, 0, 1);
        exp_at(c + 10, "s2_loss_wait",    WAIT_CLK, 0, 0, 0, 1);
        exp_at(c + 26, "s2_resettle",     SETTLE,   0, 0, 0, 1);
        exp_at(c + 27, "s2_reready",      READY,    0, 1, 0, 1);
        step(6);
        input_clk_stopped = 1'b0;
        step(25);

        // 6a: rst while READY (retry_count nonzero) clears everything
        c = cyc;
        rst = 1'b1;
        input_clk_stopped = 1'b1;
        exp_at(c + 1, "s6_rst_ready", IDLE, 1, 0, 0, 0);
        step(1);
        rst = 1'b0;

        // 3: input clock never appears -> 3 timeouts then FAULT
        c = cyc;
        exp_at(c + 1,  "s3_reset",     RESET,    1, 0, 0, 0);
        exp_at(c + 5,  "s3_wait",      WAIT_CLK, 0, 0, 0, 0);
        exp_at(c + 20, "s3_wait_last", WAIT_CLK, 0, 0, 0, 0);
        exp_at(c + 21, "s3_retry1",    RESET,    1, 0, 0, 1);
        exp_at(c + 25, "s3_wait2",     WAIT_CLK, 0, 0, 0, 1);
        exp_at(c + 41, "s3_retry2",    RESET,    1, 0, 0, 2);
        exp_at(c + 60, "s3_wait3_end", WAIT_CLK, 0, 0, 0, 2);
        exp_at(c + 61, "s3_fault",     FAULT,    1, 0, 1, 3);
        exp_at(c + 75, "s3_fault_hold", FAULT,   1, 0, 1, 3);
        step(76);

        // 4: enable low for one cycle leaves FAULT, fresh reset pulse
        c = cyc;
        enable = 1'b0;
        exp_at(c + 1, "s4_idle",       IDLE,     1, 0, 0, 0);
        exp_at(c + 2, "s4_reset",      RESET,    1, 0, 0, 0);
        exp_at(c + 5, "s4_reset_last", RESET,    1, 0, 0, 0);
        exp_at(c + 6, "s4_wait",       WAIT_CLK, 0, 0, 0, 0);
        // 5: SETTLE from c+9; one-cycle stop seen at timer=10 restarts it
        exp_at(c + 25, "s5_not_ready",   SETTLE, 0, 0, 0, 0);
        exp_at(c + 35, "s5_settle_last", SETTLE, 0, 0, 0, 0);
        exp_at(c + 36, "s5_ready",       READY,  0, 1, 0, 0);
        step(1);
        enable = 1'b1;
        step(5);
        input_clk_stopped = 1'b0;
        step(11);
        input_clk_stopped = 1'b1;
        step(1);
        input_clk_stopped = 1'b0;
        step(25);

        // 6b: enable drop on the same edge as a loss failure -> IDLE, no count
        c = cyc;
        input_clk_stopped = 1'b1;
        exp_at(c + 5, "s6_pre_fail",  READY, 0, 1, 0, 0);
        exp_at(c + 6, "s6_idle_wins", IDLE,  1, 0, 0, 0);
        exp_at(c + 9, "s6_idle_hold", IDLE,  1, 0, 0, 0);
        step(5);
        enable = 1'b0;
        step(6);

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL %s: expectation for cycle %0d never compared", e.name, e.at);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
